fetch_step_ctrl: RTL and testbench

- Generates the single-cycle advance enable (StepEn) that drives the instruction fetch unit's PC update.
- Replaces free-running clock division as the fetch pacing source.
- Two modes:
  - Step mode: one debounced press of the step button gives exactly one fetch advance.
  - Run mode: fetch advances automatically at a fixed divided rate.
- Also provides a 16-bit step counter for the seven-segment display path.

---
 rtl/fetch_step_ctrl_if.sv | 30 +++
 rtl/fetch_step_ctrl.sv | 127 ++++++++++++
 tb/tb_fetch_step_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_step_ctrl_if.sv
// fetch_step_ctrl_if: signal bundle between the board I/O / fetch unit and fetch_step_ctrl.
//   BtnStep   raw asynchronous step pushbutton, active-high
//   RunMode   raw asynchronous mode switch (1 = run, 0 = step)
//   StepEn    registered one-cycle fetch advance enable
//   Running   high while the controller is in run mode
//   StepCount number of StepEn pulses since reset, modulo 2^16
// The slave modport is the controller side; the master modport is the environment side.
interface fetch_step_ctrl_if;
  logic        BtnStep;
  logic        RunMode;
  logic        StepEn;
  logic        Running;
  logic [15:0] StepCount;

  modport master (
    output BtnStep,
    output RunMode,
    input  StepEn,
    input  Running,
    input  StepCount
  );

  modport slave (
    input  BtnStep,
    input  RunMode,
    output StepEn,
    output Running,
    output StepCount
  );
endinterface

// File: rtl/fetch_step_ctrl.sv
// fetch_step_ctrl: paces the instruction fetch unit with a single-cycle StepEn pulse.
//   Step mode: each debounced button press yields exactly one StepEn.
//   Run mode:  StepEn fires once every RUN_DIVIDE cycles.
// Ports:
//   Clk    system clock, all state on the rising edge
//   Reset  synchronous active-high reset
//   bus    fetch_step_ctrl_if.slave (BtnStep, RunMode in; StepEn, Running, StepCount out)
module fetch_step_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned RUN_DIVIDE      = 50000000
) (
  input  logic               Clk,
  input  logic               Reset,
  fetch_step_ctrl_if.slave   bus
);

  localparam int unsigned DbW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned DivW = $clog2(RUN_DIVIDE);
  localparam logic [DbW-1:0]  DbLast  = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DivW-1:0] DivLast = DivW'(RUN_DIVIDE - 1);

  typedef enum logic [1:0] {StIdle, StHeld, StRun} state_e;

  logic            r_btn_meta, r_btn_sync;
  logic            r_run_meta, r_run_sync;
  logic            r_btn_db, r_btn_db_prev;
  logic [DbW-1:0]  r_db_cnt;
  logic [DivW-1:0] r_div_cnt;
  state_e          r_state;
  logic            r_step_en;
  logic [15:0]     r_step_cnt;

  logic            w_btn_db_d;
  logic [DbW-1:0]  w_db_cnt_d;
  logic [DivW-1:0] w_div_d;
  state_e          w_state_d;
  logic            w_step_en_d;
  logic            w_btn_rise;

  // Debounce: flip the level only after DEBOUNCE_CYCLES consecutive mismatches.
  always_comb begin
    w_btn_db_d = r_btn_db;
    w_db_cnt_d = '0;
    if (r_btn_sync != r_btn_db) begin
      if (r_db_cnt == DbLast) begin
        w_btn_db_d = ~r_btn_db;
      end else begin
        w_db_cnt_d = r_db_cnt + 1'b1;
      end
    end
  end

  // Edge rather than level, so a button still held on leaving run mode does not step.
  assign w_btn_rise = r_btn_db & ~r_btn_db_prev;

  always_comb begin
    w_state_d   = r_state;
    w_div_d     = r_div_cnt;
    w_step_en_d = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (r_run_sync) begin
          w_state_d = StRun;
          w_div_d   = '0;
        end else if (w_btn_rise) begin
          w_state_d   = StHeld;
          w_step_en_d = 1'b1;
        end
      end
      StHeld: begin
        if (r_run_sync) begin
          w_state_d = StRun;
          w_div_d   = '0;
        end else if (!r_btn_db) begin
          w_state_d = StIdle;
        end
      end
      StRun: begin
        // Leaving run mode drops a pulse that would have fired on this edge.
        if (!r_run_sync) begin
          w_state_d = StIdle;
        end else if (r_div_cnt == DivLast) begin
          w_div_d     = '0;
          w_step_en_d = 1'b1;
        end else begin
          w_div_d = r_div_cnt + 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_btn_meta    <= 1'b0;
      r_btn_sync    <= 1'b0;
      r_run_meta    <= 1'b0;
      r_run_sync    <= 1'b0;
      r_btn_db      <= 1'b0;
      r_btn_db_prev <= 1'b0;
      r_db_cnt      <= '0;
      r_div_cnt     <= '0;
      r_state       <= StIdle;
      r_step_en     <= 1'b0;
      r_step_cnt    <= 16'h0000;
    end else begin
      r_btn_meta    <= bus.BtnStep;
      r_btn_sync    <= r_btn_meta;
      r_run_meta    <= bus.RunMode;
      r_run_sync    <= r_run_meta;
      r_btn_db      <= w_btn_db_d;
      r_btn_db_prev <= r_btn_db;
      r_db_cnt      <= w_db_cnt_d;
      r_div_cnt     <= w_div_d;
      r_state       <= w_state_d;
      r_step_en     <= w_step_en_d;
      if (r_step_en) begin
        r_step_cnt <= r_step_cnt + 16'h0001;
      end
    end
  end

  assign bus.StepEn    = r_step_en;
  assign bus.Running   = (r_state == StRun);
  assign bus.StepCount = r_step_cnt;

endmodule

// File: tb/tb_fetch_step_ctrl.sv
// tb_fetch_step_ctrl: directed bench for fetch_step_ctrl with DEBOUNCE_CYCLES=4, RUN_DIVIDE=8.
module tb_fetch_step_ctrl;

  logic Clk = 1'b0;
  logic Reset;

  fetch_step_ctrl_if bus ();

  fetch_step_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .RUN_DIVIDE     (8)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 Clk = ~Clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   pulses   = 0;
  int   n_consec = 0;
  logic prev_en  = 1'b0;

  // Advance one edge and sample 1 time unit after it.
  task automatic tick();
    @(posedge Clk);
    #1;
    if (bus.StepEn === 1'b1) begin
      pulses++;
      if (prev_en) n_consec++;
    end
    prev_en = bus.StepEn;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Ticks until StepEn is seen; k is the number of edges taken (bounded at 40).
  task automatic wait_step(output int k);
    k = 0;
    do begin
      tick();
      k++;
    end while (bus.StepEn !== 1'b1 && k < 40);
  endtask

  initial begin
    int k;
    int c;
    int p0;

    Reset       = 1'b1;
    bus.BtnStep = 1'b0;
    bus.RunMode = 1'b0;
    tick();
    tick();
    check("reset_stepen", 32'(bus.StepEn), 32'd0);
    check("reset_running", 32'(bus.Running), 32'd0);
    check("reset_count", 32'(bus.StepCount), 32'd0);

    // Press held 20 cycles: one pulse 7 edges after the first sampling edge.
    Reset = 1'b0;
    p0 = pulses;
    bus.BtnStep = 1'b1;
    wait_step(k);
    check("press1_latency", 32'(k), 32'd7);
    repeat (13) tick();
    check("press1_pulses", 32'(pulses - p0), 32'd1);
    check("press1_count", 32'(bus.StepCount), 32'd1);

    // Release, 3-cycle glitch (too short), then a genuine 10-cycle press.
    bus.BtnStep = 1'b0;
    repeat (10) tick();
    p0 = pulses;
    bus.BtnStep = 1'b1;
    repeat (3) tick();
    bus.BtnStep = 1'b0;
    repeat (10) tick();
    check("glitch_pulses", 32'(pulses - p0), 32'd0);
    bus.BtnStep = 1'b1;
    wait_step(k);
    check("press2_latency", 32'(k), 32'd7);
    repeat (3) tick();
    bus.BtnStep = 1'b0;
    repeat (10) tick();
    check("press2_pulses", 32'(pulses - p0), 32'd1);
    check("press2_count", 32'(bus.StepCount), 32'd2);

    // Run mode: Running after 3 edges, first pulse in the 9th cycle, then every 8.
    p0 = pulses;
    bus.RunMode = 1'b1;
    k = 0;
    do begin
      tick();
      k++;
    end while (bus.Running !== 1'b1 && k < 10);
    check("run_entry_latency", 32'(k), 32'd3);
    c = 1;
    do begin
      tick();
      c++;
    end while (bus.StepEn !== 1'b1 && c < 40);
    check("run_first_pulse", 32'(c), 32'd9);
    bus.BtnStep = 1'b1;
    wait_step(k);
    check("run_period_a", 32'(k), 32'd8);
    bus.BtnStep = 1'b0;
    wait_step(k);
    check("run_period_b", 32'(k), 32'd8);
    wait_step(k);
    check("run_period_c", 32'(k), 32'd8);
    bus.RunMode = 1'b0;
    repeat (6) tick();
    check("run_exit_running", 32'(bus.Running), 32'd0);
    check("run_pulses", 32'(pulses - p0), 32'd4);
    check("run_count", 32'(bus.StepCount), 32'd6);

    // Synchronized RunMode falls exactly as the divide counter hits 7: pulse suppressed.
    bus.RunMode = 1'b1;
    repeat (3) tick();
    wait_step(k);
    check("run2_first_pulse", 32'(k), 32'd8);
    repeat (5) tick();
    p0 = pulses;
    bus.RunMode = 1'b0;
    repeat (12) tick();
    check("exit_no_pulse", 32'(pulses - p0), 32'd0);
    check("exit_running", 32'(bus.Running), 32'd0);
    bus.BtnStep = 1'b1;
    wait_step(k);
    check("post_run_latency", 32'(k), 32'd7);
    repeat (3) tick();
    bus.BtnStep = 1'b0;
    repeat (10) tick();
    check("post_run_count", 32'(bus.StepCount), 32'd8);

    // StepCount wrap: preload 16'hFFFF, then one step.
    force dut.r_step_cnt = 16'hFFFF;
    #1;
    release dut.r_step_cnt;
    check("wrap_preload", 32'(bus.StepCount), 32'h0000FFFF);
    bus.BtnStep = 1'b1;
    wait_step(k);
    tick();
    check("wrap_count", 32'(bus.StepCount), 32'h00000000);
    bus.BtnStep = 1'b0;
    repeat (10) tick();

    // Reset while HELD with the button still down: treated as a new press afterwards.
    bus.BtnStep = 1'b1;
    wait_step(k);
    repeat (2) tick();
    Reset = 1'b1;
    tick();
    tick();
    check("rst_held_stepen", 32'(bus.StepEn), 32'd0);
    check("rst_held_running", 32'(bus.Running), 32'd0);
    check("rst_held_count", 32'(bus.StepCount), 32'd0);
    Reset = 1'b0;
    wait_step(k);
    check("rst_held_latency", 32'(k), 32'd7);
    tick();
    check("rst_held_count_after", 32'(bus.StepCount), 32'd1);
    bus.BtnStep = 1'b0;
    repeat (10) tick();

    check("no_back_to_back", 32'(n_consec), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
